cache_mem_arbiter: RTL

//  Shares the single RAM port between icache (read-only) and dcache (read/write, incl. flush writebacks).
//  One word transaction per grant; dcache has fixed priority over icache.

---
 rtl/cache_mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache (read) and dcache (read/write); dcache has fixed priority.
// Optional fairness: define ARB_FAIR_EN to force an icache grant after MAX_DSTREAK dcache words.
module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              timeout
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [7:0] WCNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] wcnt_r;
  logic       d_req_s;
  logic       access_s;
  logic       expire_s;
  logic       fair_force_s;

  assign d_req_s  = dREN | dWEN;
  assign access_s = (ramstate == RAM_ACCESS);
  assign expire_s = (wcnt_r == WCNT_LAST);
  assign iload    = ramload;
  assign dload    = ramload;

`ifdef ARB_FAIR_EN
  logic [2:0] streak_r;

  assign fair_force_s = iREN && ({29'd0, streak_r} >= 32'(MAX_DSTREAK));

  // Streak of dcache completions that happened while icache was kept waiting
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_r <= 3'd0;
    end else if (!iREN) begin
      streak_r <= 3'd0;
    end else if (state_r == IGNT && access_s) begin
      streak_r <= 3'd0;
    end else if (state_r == DGNT && d_req_s && access_s && streak_r != 3'd7) begin
      streak_r <= streak_r + 3'd1;
    end else begin
      streak_r <= streak_r;
    end
  end
`else
  logic [31:0] unused_max_dstreak_s;

  assign fair_force_s         = 1'b0;
  assign unused_max_dstreak_s = 32'(MAX_DSTREAK);
`endif

  // RAM port mux, handshake back to the caches and the abort pulse
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    timeout  = 1'b0;
    case (state_r)
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (d_req_s && access_s) begin
          dwait = 1'b0;
        end else if (d_req_s && expire_s) begin
          timeout = 1'b1;
        end else begin
          dwait = 1'b1;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (iREN && access_s) begin
          iwait = 1'b0;
        end else if (iREN && expire_s) begin
          timeout = 1'b1;
        end else begin
          iwait = 1'b1;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // Grant sequencing: one word per grant, always an idle turnaround before re-arbitration
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      wcnt_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          wcnt_r <= 8'd0;
          if (fair_force_s) begin
            state_r <= IGNT;
          end else if (d_req_s) begin
            state_r <= DGNT;
          end else if (iREN) begin
            state_r <= IGNT;
          end else begin
            state_r <= IDLE;
          end
        end
        DGNT: begin
          if (!d_req_s || access_s || expire_s) begin
            state_r <= IDLE;
            wcnt_r  <= 8'd0;
          end else begin
            wcnt_r  <= wcnt_r + 8'd1;
          end
        end
        IGNT: begin
          if (!iREN || access_s || expire_s) begin
            state_r <= IDLE;
            wcnt_r  <= 8'd0;
          end else begin
            wcnt_r  <= wcnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          wcnt_r  <= 8'd0;
        end
      endcase
    end
  end

endmodule
